// File: rtl/dma_copy_pkg.sv
// dma_copy_pkg: register map, control bit positions and FSM encoding for dma_copy
package dma_copy_pkg;
   localparam logic [1:0] REG_SRC  = 2'd0;
   localparam logic [1:0] REG_DST  = 2'd1;
   localparam logic [1:0] REG_LEN  = 2'd2;
   localparam logic [1:0] REG_CTRL = 2'd3;
   localparam int CTRL_START = 0;
   localparam int CTRL_BUSY  = 0;
   localparam int CTRL_DONE  = 1;
   typedef enum logic [2:0] {IDLE, RD, RGAP, WR, WGAP} state_t;
endpackage

// File: rtl/dma_copy_regs.sv
// dma_copy_regs: register-port decode, ready flop, SRC/DST/LEN storage and readback mux
module dma_copy_regs
   import dma_copy_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              enable,
   input  logic              mem_valid,
   input  logic [3:0]        mem_wstrb,
   input  logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_addr,
   input  logic              busy,
   input  logic              done,
   input  logic [ADDR_W-1:0] work_src,
   input  logic [ADDR_W-1:0] work_dst,
   input  logic [LEN_W-1:0]  work_cnt,
   output logic              mem_ready,
   output logic [31:0]       mem_rdata,
   output logic [ADDR_W-1:0] src,
   output logic [ADDR_W-1:0] dst,
   output logic [LEN_W-1:0]  len,
   output logic              start
);
   logic [1:0]  sel;
   logic        wr;
   logic [31:0] ctrl;
   logic        unused;
   assign sel    = mem_addr[3:2];
   assign wr     = mem_valid & enable & |mem_wstrb;
   assign start  = wr && sel == REG_CTRL && mem_wdata[CTRL_START];
   assign unused = ^{mem_addr[31:4], mem_addr[1:0]};
   always_ff @(posedge clk) begin
      if (!resetn) begin
         mem_ready <= 1'b0;
         src       <= '0;
         dst       <= '0;
         len       <= '0;
      end else begin
         mem_ready <= mem_valid & enable;
         if (wr && !busy && sel == REG_SRC) src <= {mem_wdata[ADDR_W-1:2], 2'b00};
         if (wr && !busy && sel == REG_DST) dst <= {mem_wdata[ADDR_W-1:2], 2'b00};
         if (wr && !busy && sel == REG_LEN) len <= mem_wdata[LEN_W-1:0];
      end
   end
   // while busy the working counters are shown so software can watch progress
   always_comb begin
      ctrl            = '0;
      ctrl[CTRL_BUSY] = busy;
      ctrl[CTRL_DONE] = done;
      mem_rdata = !enable          ? '0 :
                  sel == REG_SRC   ? 32'(busy ? work_src : src) :
                  sel == REG_DST   ? 32'(busy ? work_dst : dst) :
                  sel == REG_LEN   ? 32'(busy ? work_cnt : len) : ctrl;
   end
endmodule

// File: rtl/dma_copy.sv
// dma_copy: memory-to-memory word copy engine with a register port and a master port
module dma_copy
   import dma_copy_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        enable,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic        mem_instr,
   input  logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_wdata,
   input  logic [31:0] mem_addr,
   output logic [31:0] mem_rdata,
   output logic        m_mem_valid,
   input  logic        m_mem_ready,
   output logic        m_mem_instr,
   output logic [3:0]  m_mem_wstrb,
   output logic [31:0] m_mem_wdata,
   output logic [31:0] m_mem_addr,
   input  logic [31:0] m_mem_rdata
);
   state_t            state, next;
   logic [ADDR_W-1:0] reg_src, reg_dst, src, dst;
   logic [LEN_W-1:0]  reg_len, cnt;
   logic [31:0]       data;
   logic              done, busy, start, go, unused;
   assign busy   = state != IDLE;
   assign go     = start && !busy;
   assign unused = mem_instr;
   dma_copy_regs #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_regs (
      .clk(clk), .resetn(resetn), .enable(enable), .mem_valid(mem_valid),
      .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
      .busy(busy), .done(done), .work_src(src), .work_dst(dst), .work_cnt(cnt),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .src(reg_src), .dst(reg_dst), .len(reg_len), .start(start)
   );
   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else state <= next;
   end
   // the gap states drop valid so a responder's held ready is never mistaken for a new ack
   always_comb begin
      next = state;
      case (state)
         IDLE:    if (go && reg_len != '0) next = RD;
         RD:      if (m_mem_ready) next = RGAP;
         RGAP:    next = WR;
         WR:      if (m_mem_ready) next = WGAP;
         WGAP:    next = cnt != '0 ? RD : IDLE;
         default: next = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         src  <= '0;
         dst  <= '0;
         cnt  <= '0;
         data <= '0;
         done <= 1'b0;
      end else begin
         if (go) begin
            src  <= reg_src;
            dst  <= reg_dst;
            cnt  <= reg_len;
            done <= reg_len == '0;
         end
         if (state == RD && m_mem_ready) begin
            data <= m_mem_rdata;
            src  <= src + ADDR_W'(4);
         end
         if (state == WR && m_mem_ready) begin
            dst <= dst + ADDR_W'(4);
            cnt <= cnt - LEN_W'(1);
         end
         if (state == WGAP && cnt == '0) done <= 1'b1;
      end
   end
   assign m_mem_valid = state == RD || state == WR;
   assign m_mem_instr = 1'b0;
   assign m_mem_wstrb = state == WR ? 4'hF : 4'h0;
   assign m_mem_addr  = state == RD ? 32'(src) : state == WR ? 32'(dst) : '0;
   assign m_mem_wdata = state == WR ? data : '0;
endmodule
